// File: rtl/main_mem_resp.sv
// Main-memory responder for the cache refill/write path: accepts one request,
// waits LATENCY cycles, performs the access and holds the response until taken.
module main_mem_resp #(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                access;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        access     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the array is deliberately reset to a known pattern, which forces
    // it into flops rather than a RAM macro.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
            resp_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(32'h80 + 32'(i));
            end
        end else begin
            if (accept) begin
                cap_we   <= req_we;
                cap_addr <= req_addr;
                cap_data <= req_data;
                cnt      <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // A write commits only here and echoes its data as the response.
            if (access) begin
                if (cap_we) begin
                    mem[cap_addr] <= cap_data;
                    resp_data     <= cap_data;
                end else begin
                    resp_data <= mem[cap_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_main_mem_resp.sv
// Directed self-checking bench for main_mem_resp: one instance at LATENCY=3
// and one at LATENCY=1, sharing clock and reset.
module tb_main_mem_resp;

    logic       clock;
    logic       reset;

    logic       req, req_we, resp_ready;
    logic [4:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready, resp_valid, busy;
    logic [7:0] resp_data;

    logic       req1, req_we1, resp_ready1;
    logic [4:0] req_addr1;
    logic [7:0] req_data1;
    logic       req_ready1, resp_valid1, busy1;
    logic [7:0] resp_data1;

    int n_checks = 0;
    int n_errors = 0;

    main_mem_resp #(.LATENCY(3), .ADDR_W(5), .DATA_W(8)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_ready(resp_ready),
        .busy      (busy)
    );

    main_mem_resp #(.LATENCY(1), .ADDR_W(5), .DATA_W(8)) u_dut_l1 (
        .clock     (clock),
        .reset     (reset),
        .req       (req1),
        .req_we    (req_we1),
        .req_addr  (req_addr1),
        .req_data  (req_data1),
        .req_ready (req_ready1),
        .resp_valid(resp_valid1),
        .resp_data (resp_data1),
        .resp_ready(resp_ready1),
        .busy      (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request on the LATENCY=3 instance with resp_ready=1; returns the
    // response data and the number of edges from acceptance to resp_valid.
    task automatic transact(input logic we, input logic [4:0] addr, input logic [7:0] data,
                            output logic [7:0] rdata, output int lat);
        resp_ready = 1'b1;
        req        = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_data   = data;
        step();
        req = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        rdata = resp_data;
        step();
    endtask

    logic [7:0] rd;
    int         lat;
    int         n;

    initial begin
        reset       = 1'b1;
        req         = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        resp_ready  = 1'b0;
        req1        = 1'b0;
        req_we1     = 1'b0;
        req_addr1   = '0;
        req_data1   = '0;
        resp_ready1 = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_req_ready",  req_ready,  1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy",       busy,       0);
        check("rst_resp_data",  resp_data,  8'h00);

        // Read 0x05 with LATENCY=3, cycle by cycle.
        resp_ready = 1'b1;
        req        = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h05;
        step();
        req = 1'b0;
        check("rd05_busy_e0",  busy,       1);
        check("rd05_ready_e0", req_ready,  0);
        check("rd05_valid_e0", resp_valid, 0);
        step();
        check("rd05_valid_e1", resp_valid, 0);
        step();
        check("rd05_valid_e2", resp_valid, 0);
        step();
        check("rd05_valid_e3", resp_valid, 1);
        check("rd05_data",     resp_data,  8'h85);
        step();
        check("rd05_valid_e4", resp_valid, 0);
        check("rd05_ready_e4", req_ready,  1);
        check("rd05_busy_e4",  busy,       0);
        check("rd05_data_kept", resp_data, 8'h85);

        // Write then read back, neighbour untouched.
        transact(1'b1, 5'h1A, 8'h3C, rd, lat);
        check("wr1a_echo", rd,  8'h3C);
        check("wr1a_lat",  lat, 3);
        transact(1'b0, 5'h1A, 8'h00, rd, lat);
        check("rd1a_data", rd,  8'h3C);
        check("rd1a_lat",  lat, 3);
        transact(1'b0, 5'h19, 8'h00, rd, lat);
        check("rd19_data", rd,  8'h99);

        // Held response with ignored request pulses.
        resp_ready = 1'b0;
        req        = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h02;
        step();
        req = 1'b0;
        step();
        step();
        step();
        check("hold_valid_rise", resp_valid, 1);
        check("hold_data_rise",  resp_data,  8'h82);
        for (int i = 0; i < 5; i++) begin
            req      = (i % 2 == 0);
            req_we   = 1'b1;
            req_addr = 5'h02;
            req_data = 8'h55;
            step();
            check("hold_valid", resp_valid, 1);
            check("hold_data",  resp_data,  8'h82);
            check("hold_ready", req_ready,  0);
        end
        req        = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        step();
        check("hold_hs_valid", resp_valid, 0);
        check("hold_hs_ready", req_ready,  1);
        transact(1'b0, 5'h02, 8'h00, rd, lat);
        check("hold_mem_kept", rd, 8'h82);

        // Back-to-back: acceptances every LATENCY+2 = 5 edges.
        resp_ready = 1'b1;
        req        = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h03;
        for (int e = 0; e < 12; e++) begin
            check("b2b_ready", req_ready, (e % 5 == 0) ? 1 : 0);
            step();
            check("b2b_busy",  busy,      (e % 5 < 4) ? 1 : 0);
        end
        req = 1'b0;
        n   = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("b2b_drain", req_ready, 1);

        // Reset during WAIT with cnt=1 aborts the write.
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = 5'h07;
        req_data = 8'hFF;
        step();
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", resp_valid, 0);
        check("abort_ready", req_ready,  1);
        check("abort_busy",  busy,       0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_resp", resp_valid, 0);
        end
        transact(1'b0, 5'h07, 8'h00, rd, lat);
        check("abort_mem7", rd, 8'h87);
        transact(1'b0, 5'h1A, 8'h00, rd, lat);
        check("reset_restores_1a", rd, 8'h9A);

        // Reset during RESP drops the response.
        resp_ready = 1'b0;
        req        = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h04;
        step();
        req = 1'b0;
        step();
        step();
        step();
        check("rst_resp_pre", resp_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_resp_drop",  resp_valid, 0);
        check("rst_resp_idle",  req_ready,  1);
        check("rst_resp_data0", resp_data,  8'h00);
        resp_ready = 1'b1;

        // LATENCY=1 instance: read 0x1F.
        resp_ready1 = 1'b0;
        req1        = 1'b1;
        req_we1     = 1'b0;
        req_addr1   = 5'h1F;
        step();
        req1 = 1'b0;
        check("l1_valid_e0", resp_valid1, 0);
        check("l1_busy_e0",  busy1,       1);
        step();
        check("l1_valid_e1", resp_valid1, 1);
        check("l1_data",     resp_data1,  8'h9F);
        resp_ready1 = 1'b1;
        step();
        check("l1_valid_hs", resp_valid1, 0);
        check("l1_ready_hs", req_ready1,  1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/main_mem_resp.md
MAIN_MEM_RESP -- requirements
Module: main_mem_resp

Interface
REQ-001 Parameter LATENCY, default 3, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter ADDR_W, default 5, word address width; the memory depth is 2^ADDR_W.
REQ-003 Parameter DATA_W, default 8, data width.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  1  request valid from the cache miss/write path.
REQ-007 req_we  in  1  1 = write, 0 = read (refill).
REQ-008 req_addr  in  ADDR_W  word address; {tag, index} as used by the cache.
REQ-009 req_data  in  DATA_W  write data.
REQ-010 req_ready  out  1  responder can accept a request.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_data  out  DATA_W  read data, or echo of write data.
REQ-013 resp_ready  in  1  requester accepts the response.
REQ-014 busy  out  1  high while a request is outstanding (WAIT or RESP).

Function
REQ-015 The block SHALL implement an FSM with the states IDLE, WAIT and RESP, and SHALL store 2^ADDR_W words of DATA_W bits in a register array.
REQ-016 In IDLE the block SHALL assert req_ready=1, resp_valid=0 and busy=0; in WAIT and RESP it SHALL assert req_ready=0 and busy=1.
REQ-017 Request acceptance SHALL occur at a rising edge where req=1 and the state is IDLE; at that edge the block SHALL capture req_we, req_addr and req_data, load cnt=LATENCY-1, and enter WAIT.
REQ-018 While req_ready=0, req SHALL be ignored, with no capture and no side effect.
REQ-019 In WAIT, at each edge: if cnt≠0 the block SHALL decrement cnt; if cnt=0 it SHALL perform the access and enter RESP.
REQ-020 A read access SHALL load resp_data with mem[captured addr].
REQ-021 A write access SHALL set mem[captured addr] to the captured data and load resp_data with the captured data; a write therefore also produces one response.
REQ-022 resp_valid SHALL rise exactly LATENCY rising edges after the acceptance edge.
REQ-023 cnt SHALL be 4 bits wide and SHALL never wrap; it is loaded only on acceptance.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_data SHALL hold stable until an edge with resp_ready=1.
REQ-025 At that edge the block SHALL return to IDLE; the next acceptance is possible at the following edge at the earliest, giving a minimum spacing of LATENCY+2 edges between acceptances.
REQ-026 If resp_ready is already 1 when RESP is entered, the handshake SHALL complete at the first RESP edge, so resp_valid is high for exactly one cycle.
REQ-027 After a handshake, resp_data SHALL retain its last value; it is don't-care while resp_valid=0 but must not change except at an access.
REQ-028 A read issued after a write to the same address SHALL return the written data.
REQ-029 The memory array SHALL be modified only at the write-access edge.

Reset
REQ-030 On a rising edge with reset=1, the block SHALL set state=IDLE, cnt=0, resp_valid=0, resp_data=0, busy=0 and, from the next cycle, req_ready=1.
REQ-031 Reset SHALL initialise mem[i] = (8'h80 + i) truncated to DATA_W, for every i.
REQ-032 Reset SHALL take priority over every other event, including req, resp_ready, or a pending access in the same cycle.
REQ-033 Reset during WAIT SHALL abort the request; a write not yet committed SHALL NOT be committed, and no response SHALL be produced.
REQ-034 Reset during RESP SHALL drop resp_valid to 0 at that edge, with the response lost.

Verification
REQ-035 Reset, then a read of addr 5'h05 with LATENCY=3 and resp_ready=1 -> accept at edge E, resp_valid=1 at E+3 for one cycle, resp_data=8'h85, back in IDLE at E+4.
REQ-036 Write 8'h3C to addr 5'h1A, then read 5'h1A -> the write response echoes 8'h3C and the read returns 8'h3C; addr 5'h19 still reads 8'h99.
REQ-037 Read addr 5'h02 with resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid and resp_data=8'h82 are held stable; handshake on the resp_ready=1 edge; req pulses during this interval are ignored and mem is unchanged.
REQ-038 Back-to-back req held high for 10 cycles with resp_ready=1 -> acceptances spaced exactly LATENCY+2 edges apart, with busy=1 between each acceptance and its handshake.
REQ-039 Write 8'hFF to addr 5'h07 with reset asserted during WAIT (cnt=1) -> no response; after reset mem[7] reads 8'h87 and req_ready=1.
REQ-040 Set LATENCY=1 and read addr 5'h1F -> resp_valid at the first edge after acceptance, resp_data=8'h9F.
